ica_sequencer: RTL and testbench
================================

ICA_SEQUENCER -- requirements
Module: ica_sequencer

Interface
REQ-001 SHALL provide parameter MAX_ITER, default 64: fixed-point iteration limit per component (2..255).
REQ-002 SHALL provide parameter N_COMP, default 4: number of independent components extracted (1..4).
REQ-003 SHALL provide parameter TIMEOUT, default 1023: maximum wait cycles per handshake phase (1..1023).
REQ-004 CLK_ica  input  1  single clock; all state changes on its rising edge.
REQ-005 RSTn_ica  input  1  reset, asynchronous, active-low.
REQ-006 GO_ica  input  1  start request; sampled only in IDLE and ERR.
REQ-007 New_one  input  1  abort request; highest priority in every state.
REQ-008 GO_whitening  output  1  one-cycle start pulse to the whitening block.
REQ-009 Whitening_busy  input  1  whitening block busy.
REQ-010 GO_fixed  output  1  one-cycle start pulse to the fixed-point iteration unit.
REQ-011 Fixed_busy  input  1  fixed-point unit busy.
REQ-012 Converged  input  1  iteration result; valid in the cycle Fixed_busy is first seen low in FP_RUN.
REQ-013 Comp_idx  output  2  component currently being extracted.
REQ-014 Iter_cnt  output  8  completed iterations for the current component.
REQ-015 Nonconv_mask  output  4  bit k set: component k hit MAX_ITER without converging.
REQ-016 Ica_busy  output  1  high in every state except IDLE and ERR.
REQ-017 Ica_done  output  1  one-cycle completion pulse.
REQ-018 Timeout_err  output  1  sticky handshake timeout flag.

Function
REQ-019 SHALL drive all outputs from registers.
REQ-020 SHALL implement states IDLE, WH_START, WH_ACK, WH_RUN, FP_START, FP_ACK, FP_RUN, DONE, ERR.
REQ-021 IDLE with GO_ica=1 at edge t SHALL enter WH_START; GO_whitening=1 and Ica_busy=1 during cycle t+1 only.
REQ-022 GO_ica=1 in IDLE SHALL also clear Comp_idx, Iter_cnt, Nonconv_mask, Timeout_err.
REQ-023 WH_START SHALL go to WH_ACK unconditionally; WH_ACK SHALL go to WH_RUN when Whitening_busy=1 (an already-high busy counts).
REQ-024 WH_RUN SHALL go to FP_START when Whitening_busy=0.
REQ-025 FP_START SHALL assert GO_fixed for exactly one cycle, then go to FP_ACK; FP_ACK/FP_RUN SHALL mirror REQ-023/024 using Fixed_busy.
REQ-026 On Fixed_busy=0 in FP_RUN SHALL increment Iter_cnt (8-bit, no wrap: MAX_ITER<=255).
REQ-027 Component finished when Converged=1, or Converged=0 with incremented Iter_cnt==MAX_ITER (then set Nonconv_mask[Comp_idx]); otherwise go to FP_START.
REQ-028 Finished component with Comp_idx<N_COMP-1 SHALL increment Comp_idx, clear Iter_cnt, go to FP_START; with Comp_idx==N_COMP-1 SHALL go to DONE.
REQ-029 DONE SHALL assert Ica_done for one cycle then go to IDLE; Comp_idx, Iter_cnt, Nonconv_mask SHALL hold until next start.
REQ-030 A wait counter SHALL clear on entry to each ACK/RUN state; reaching TIMEOUT cycles there SHALL enter ERR, setting Timeout_err=1.
REQ-031 ERR SHALL hold Ica_busy=0 and all counters; GO_ica=1 SHALL restart as REQ-021/022.
REQ-032 New_one=1 in any state SHALL force IDLE next cycle, GO pulses 0, Comp_idx/Iter_cnt/wait counter cleared, Timeout_err cleared, Nonconv_mask held; New_one beats simultaneous GO_ica.
REQ-033 GO_ica in states other than IDLE/ERR SHALL be ignored.

Reset
REQ-034 RSTn_ica=0 SHALL immediately force IDLE and all outputs/counters to 0, including mid-operation, without emitting any pulse.
REQ-035 First edge after RSTn_ica deassertion SHALL behave as IDLE.

Verification (bench parameters MAX_ITER=4, N_COMP=4, TIMEOUT=8)
REQ-036 Nominal: GO_ica pulse, model busy 3 cycles each, Converged=1 on 2nd iteration -> one GO_whitening, 8 GO_fixed, Ica_done once, Iter_cnt=2, Comp_idx=3, Nonconv_mask=0000.
REQ-037 Non-convergence: Converged=0 always for component 1 -> 4 iterations on comp 1, Nonconv_mask=0010, Ica_done still asserted.
REQ-038 Timeout: Whitening_busy never rises -> ERR after 8 cycles in WH_ACK, Timeout_err=1, Ica_busy=0; later GO_ica clears flag and restarts.
REQ-039 Abort: New_one=1 together with GO_ica during FP_RUN of comp 2 -> IDLE next cycle, Comp_idx=0, Iter_cnt=0, no Ica_done, no restart.
REQ-040 Reset mid-run: RSTn_ica low during WH_RUN -> all outputs 0 asynchronously; GO_ica ignored while reset low.

Source files
------------

// File: rtl/ica_sequencer.sv
// ica_sequencer: sequences whitening then per-component fixed-point iterations for ICA,
// with per-phase handshake timeouts, abort and registered outputs.
module ica_sequencer #(
  parameter int MAX_ITER = 64,
  parameter int N_COMP   = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic       CLK_ica,
  input  logic       RSTn_ica,
  input  logic       GO_ica,
  input  logic       New_one,
  output logic       GO_whitening,
  input  logic       Whitening_busy,
  output logic       GO_fixed,
  input  logic       Fixed_busy,
  input  logic       Converged,
  output logic [1:0] Comp_idx,
  output logic [7:0] Iter_cnt,
  output logic [3:0] Nonconv_mask,
  output logic       Ica_busy,
  output logic       Ica_done,
  output logic       Timeout_err
);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WH_START = 4'd1;
  localparam logic [3:0] S_WH_ACK   = 4'd2;
  localparam logic [3:0] S_WH_RUN   = 4'd3;
  localparam logic [3:0] S_FP_START = 4'd4;
  localparam logic [3:0] S_FP_ACK   = 4'd5;
  localparam logic [3:0] S_FP_RUN   = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;
  localparam logic [1:0] LAST = 2'(N_COMP - 1);
  localparam logic [7:0] MAXI = 8'(MAX_ITER);
  localparam logic [9:0] TLIM = 10'(TIMEOUT - 1);

  logic [3:0] r_state, w_next;
  logic [9:0] r_wait;
  logic [1:0] r_comp;
  logic [7:0] r_iter;
  logic [3:0] r_mask;
  logic       r_go_wh, r_go_fx, r_busy, r_done, r_terr;
  logic [7:0] w_iter;
  logic       w_fin, w_tmo, w_wst, w_start;

  assign w_iter  = r_iter + 8'd1;
  assign w_fin   = Converged || w_iter == MAXI;
  assign w_tmo   = r_wait == TLIM;
  assign w_wst   = r_state == S_WH_ACK || r_state == S_WH_RUN || r_state == S_FP_ACK || r_state == S_FP_RUN;
  assign w_start = (r_state == S_IDLE || r_state == S_ERR) && GO_ica;

  // Leaving a wait state takes precedence over a timeout landing on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR: w_next = GO_ica ? S_WH_START : r_state;
      S_WH_START:    w_next = S_WH_ACK;
      S_WH_ACK:      w_next = Whitening_busy ? S_WH_RUN : w_tmo ? S_ERR : r_state;
      S_WH_RUN:      w_next = !Whitening_busy ? S_FP_START : w_tmo ? S_ERR : r_state;
      S_FP_START:    w_next = S_FP_ACK;
      S_FP_ACK:      w_next = Fixed_busy ? S_FP_RUN : w_tmo ? S_ERR : r_state;
      S_FP_RUN:      w_next = !Fixed_busy ? ((w_fin && r_comp == LAST) ? S_DONE : S_FP_START)
                                          : w_tmo ? S_ERR : r_state;
      default:       w_next = S_IDLE;
    endcase
    if (New_one) w_next = S_IDLE;
  end

  always_ff @(posedge CLK_ica or negedge RSTn_ica) begin
    if (!RSTn_ica) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_comp  <= '0;
      r_iter  <= '0;
      r_mask  <= '0;
      r_go_wh <= 1'b0;
      r_go_fx <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_go_wh <= w_next == S_WH_START;
      r_go_fx <= w_next == S_FP_START;
      r_busy  <= w_next != S_IDLE && w_next != S_ERR;
      r_done  <= w_next == S_DONE;
      r_wait  <= (w_wst && w_next == r_state) ? r_wait + 10'd1 : '0;
      if (New_one) begin
        r_comp <= '0;
        r_iter <= '0;
        r_terr <= 1'b0;
      end else if (w_start) begin
        r_comp <= '0;
        r_iter <= '0;
        r_mask <= '0;
        r_terr <= 1'b0;
      end else if (w_next == S_ERR) begin
        r_terr <= 1'b1;
      end else if (r_state == S_FP_RUN && !Fixed_busy) begin
        if (!Converged && w_iter == MAXI) r_mask[r_comp] <= 1'b1;
        if (w_fin && r_comp != LAST) begin
          r_comp <= r_comp + 2'd1;
          r_iter <= '0;
        end else begin
          r_iter <= w_iter;
        end
      end
    end
  end

  assign GO_whitening = r_go_wh;
  assign GO_fixed     = r_go_fx;
  assign Comp_idx     = r_comp;
  assign Iter_cnt     = r_iter;
  assign Nonconv_mask = r_mask;
  assign Ica_busy     = r_busy;
  assign Ica_done     = r_done;
  assign Timeout_err  = r_terr;
endmodule

// File: tb/tb_ica_sequencer.sv
// tb_ica_sequencer: directed checks of ica_sequencer with busy-responder models
// for the whitening and fixed-point blocks (MAX_ITER=4, N_COMP=4, TIMEOUT=8).
module tb_ica_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0, abort = 1'b0;
  logic       wh_busy = 1'b0, fx_busy = 1'b0, conv = 1'b0;
  logic       go_wh, go_fx, busy, done, terr;
  logic [1:0] comp;
  logic [7:0] iter;
  logic [3:0] mask;
  int ncmp = 0, nfail = 0;
  int nwh = 0, nfx = 0, ndone = 0;
  int wh_cnt = 0, fx_cnt = 0, m_iter = 0, m_comp = 0, nc_comp = -1;
  bit wh_en = 1'b1;
  int w0, f0, d0;

  ica_sequencer #(.MAX_ITER(4), .N_COMP(4), .TIMEOUT(8)) dut (
    .CLK_ica(clk), .RSTn_ica(rst_n), .GO_ica(go), .New_one(abort),
    .GO_whitening(go_wh), .Whitening_busy(wh_busy),
    .GO_fixed(go_fx), .Fixed_busy(fx_busy), .Converged(conv),
    .Comp_idx(comp), .Iter_cnt(iter), .Nonconv_mask(mask),
    .Ica_busy(busy), .Ica_done(done), .Timeout_err(terr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    nwh   <= nwh + int'(go_wh);
    nfx   <= nfx + int'(go_fx);
    ndone <= ndone + int'(done);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start;
    go = 1'b1;
    tick;
    go = 1'b0;
  endtask

  task automatic model_reset(input int nc);
    m_iter = 0;
    m_comp = 0;
    nc_comp = nc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick;
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic all_zero(input string tag);
    check(tag, {13'd0, go_wh, go_fx, comp, iter, mask, busy, done, terr}, 32'd0);
  endtask

  initial begin
    // Responders: busy for 3 cycles after each start pulse; Converged decided at busy fall.
    fork
      forever begin
        @(negedge clk);
        if (wh_cnt > 0) begin
          wh_cnt--;
          if (wh_cnt == 0) wh_busy = 1'b0;
        end else if (go_wh && wh_en) begin
          wh_busy = 1'b1;
          wh_cnt = 3;
        end
        if (fx_cnt > 0) begin
          fx_cnt--;
          if (fx_cnt == 0) begin
            fx_busy = 1'b0;
            m_iter++;
            conv = (m_comp != nc_comp) && m_iter == 2;
            if (conv || m_iter == 4) begin
              m_iter = 0;
              m_comp++;
            end
          end
        end else if (go_fx) begin
          fx_busy = 1'b1;
          fx_cnt = 3;
          conv = 1'b0;
        end
      end
    join_none

    repeat (3) tick;
    all_zero("reset_outputs");
    rst_n = 1'b1;
    tick;
    all_zero("post_reset_idle");

    // Nominal run, GO_ica mid-run must be ignored
    model_reset(-1);
    w0 = nwh; f0 = nfx; d0 = ndone;
    start;
    check("nom_go_wh_busy", {30'd0, go_wh, busy}, 32'h3);
    tick;
    check("nom_go_wh_one_cycle", 32'(go_wh), 32'd0);
    repeat (4) tick;
    start;
    wait_done("nom_done", 300);
    check("nom_comp_iter_mask", {18'd0, comp, iter, mask}, {18'd0, 2'd3, 8'd2, 4'b0000});
    check("nom_wh_pulses", 32'(nwh - w0), 32'd1);
    check("nom_fx_pulses", 32'(nfx - f0), 32'd8);
    tick;
    tick;
    check("nom_done_pulses", 32'(ndone - d0), 32'd1);
    check("nom_idle_busy_done", {30'd0, busy, done}, 32'd0);
    check("nom_hold_results", {18'd0, comp, iter, mask}, {18'd0, 2'd3, 8'd2, 4'b0000});

    // Component 1 never converges
    model_reset(1);
    f0 = nfx; d0 = ndone;
    start;
    wait_done("nc_done", 400);
    check("nc_mask", 32'(mask), 32'b0010);
    check("nc_comp_iter", {22'd0, comp, iter}, {22'd0, 2'd3, 8'd2});
    check("nc_fx_pulses", 32'(nfx - f0), 32'd10);
    tick;
    tick;
    check("nc_done_pulses", 32'(ndone - d0), 32'd1);

    // Whitening handshake timeout
    wh_en = 1'b0;
    start;
    check("to_mask_cleared", 32'(mask), 32'd0);
    repeat (8) tick;
    check("to_still_waiting", {30'd0, busy, terr}, 32'b10);
    tick;
    check("to_err_entered", {30'd0, busy, terr}, 32'b01);
    repeat (3) tick;
    check("to_err_held", {30'd0, busy, terr}, 32'b01);
    wh_en = 1'b1;
    model_reset(-1);
    start;
    check("to_restart", {29'd0, go_wh, busy, terr}, 32'b110);
    wait_done("to_restart_done", 300);
    check("to_restart_flags", {27'd0, terr, mask}, 32'd0);
    tick;
    tick;

    // Abort with simultaneous GO_ica during comp 2, second iteration
    model_reset(-1);
    d0 = ndone;
    start;
    begin
      int n = 0;
      while (!(comp == 2'd2 && iter == 8'd1 && fx_busy) && n < 200) begin
        tick;
        n++;
      end
      check("ab_reached_comp2", {22'd0, comp, iter}, {22'd0, 2'd2, 8'd1});
    end
    tick;
    tick;
    abort = 1'b1;
    go = 1'b1;
    tick;
    abort = 1'b0;
    go = 1'b0;
    check("ab_idle_cleared", {19'd0, go_wh, go_fx, busy, comp, iter}, 32'd0);
    w0 = nwh;
    repeat (20) tick;
    check("ab_no_done", 32'(ndone - d0), 32'd0);
    check("ab_no_restart", {31'd0, busy}, 32'd0);
    check("ab_no_wh_pulse", 32'(nwh - w0), 32'd0);

    // Asynchronous reset during WH_RUN
    repeat (5) tick;
    model_reset(-1);
    start;
    begin
      int n = 0;
      while (!wh_busy && n < 20) begin
        tick;
        n++;
      end
      check("rst_wh_busy_seen", 32'(wh_busy), 32'd1);
    end
    tick;
    tick;
    check("rst_in_run", 32'(busy), 32'd1);
    rst_n = 1'b0;
    go = 1'b1;
    #1;
    all_zero("rst_async_zero");
    repeat (3) tick;
    all_zero("rst_held_go_ignored");
    go = 1'b0;
    rst_n = 1'b1;
    tick;
    all_zero("rst_release_idle");
    start;
    check("rst_restart", {30'd0, go_wh, busy}, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
